// File: rtl/eq_engine.sv
// Multi-channel, multi-band parametric equalizer built around one
// time-multiplexed biquad MAC. Each (channel, band) pair costs five MAC
// cycles plus one write-back cycle. Coefficients are runtime-writable, and
// a one-entry slot holds a write that arrives while a sample is in flight.
module eq_engine #(
  parameter int DATA_W    = 16,
  parameter int NUM_CH    = 2,
  parameter int NUM_BANDS = 6,
  parameter int COEF_W    = 18,
  parameter int COEF_FRAC = 16,
  parameter int INT_W     = 24,
  parameter int MAX_SHIFT = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic [NUM_CH*DATA_W-1:0]     i_data,
  input  logic [2:0]                   i_shift,
  input  logic                         i_bypass,
  input  logic                         i_clr_state,
  input  logic                         i_coef_we,
  input  logic [$clog2(NUM_BANDS)-1:0] i_coef_band,
  input  logic [2:0]                   i_coef_idx,
  input  logic [COEF_W-1:0]            i_coef_data,
  output logic [NUM_CH*DATA_W-1:0]     o_data,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_sat,
  output logic                         o_drop
);

  localparam int ACC_W  = INT_W + COEF_W + 3;
  localparam int PROD_W = INT_W + COEF_W;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CB_W   = $clog2(NUM_BANDS);

  localparam logic signed [COEF_W-1:0] COEF_ONE = {{(COEF_W-1){1'b0}}, 1'b1} << COEF_FRAC;
  localparam logic signed [ACC_W-1:0]  RND      = {{(ACC_W-1){1'b0}}, 1'b1} << (COEF_FRAC - 1);
  localparam logic signed [ACC_W-1:0]  IMAX     = ACC_W'({1'b0, {(INT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0]  IMIN     = -IMAX - 1;
  localparam logic signed [INT_W-1:0]  DMAX     = INT_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [INT_W-1:0]  DMIN     = -DMAX - 1;
  localparam logic [2:0]               MAX_SH3  = 3'(MAX_SHIFT);
  localparam logic [CH_W-1:0]          LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [BAND_W-1:0]        LAST_BD  = BAND_W'(NUM_BANDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_WB,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic signed [COEF_W-1:0] coef [NUM_BANDS][5];
  logic signed [INT_W-1:0]  hx1  [NUM_CH][NUM_BANDS];
  logic signed [INT_W-1:0]  hx2  [NUM_CH][NUM_BANDS];
  logic signed [INT_W-1:0]  hy1  [NUM_CH][NUM_BANDS];
  logic signed [INT_W-1:0]  hy2  [NUM_CH][NUM_BANDS];

  logic [NUM_CH*DATA_W-1:0] cap_data;
  logic [2:0]               cap_shift;
  logic                     cap_bypass;
  logic signed [INT_W-1:0]  samp [NUM_CH];
  logic signed [INT_W-1:0]  res  [NUM_CH];
  logic signed [INT_W-1:0]  x_cur;
  logic [CH_W-1:0]          ch;
  logic [BAND_W-1:0]        band;
  logic [2:0]               term;
  logic signed [ACC_W-1:0]  acc;
  logic                     sat_flag;

  logic                     pend_valid;
  logic [CB_W-1:0]          pend_band;
  logic [2:0]               pend_idx;
  logic [COEF_W-1:0]        pend_data;

  logic                     coef_ok;
  logic [2:0]               shift_eff;
  logic signed [INT_W-1:0]  load_val [NUM_CH];
  logic signed [INT_W-1:0]  x_in;
  logic signed [INT_W-1:0]  opnd;
  logic signed [PROD_W-1:0] c_ext;
  logic signed [PROD_W-1:0] o_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term_val;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [INT_W-1:0]  y_sat;
  logic                     wb_clamp;
  logic signed [INT_W-1:0]  y_wb;
  logic [NUM_CH*DATA_W-1:0] out_word;
  logic                     done_clamp;

  assign o_busy  = (state != S_IDLE);
  assign coef_ok = i_coef_we && (32'(i_coef_band) < NUM_BANDS) && (i_coef_idx <= 3'd4);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state sequencing: load, then MAC/WB per band and channel, then done
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_valid) state_next = S_LOAD;
      S_LOAD: state_next = S_MAC;
      S_MAC:  if (term == 3'd4) state_next = S_WB;
      S_WB:   state_next = (band == LAST_BD && ch == LAST_CH) ? S_DONE : S_MAC;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Input scaling, MAC term selection, rounding and saturation
  always_comb begin
    shift_eff = (cap_shift > MAX_SH3) ? 3'd0 : cap_shift;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      load_val[c] = INT_W'($signed(cap_data[c*DATA_W +: DATA_W])) >>> shift_eff;
    end

    x_in = (band == '0) ? samp[ch] : x_cur;
    case (term)
      3'd0:    opnd = x_in;
      3'd1:    opnd = hx1[ch][band];
      3'd2:    opnd = hx2[ch][band];
      3'd3:    opnd = hy1[ch][band];
      default: opnd = hy2[ch][band];
    endcase
    c_ext    = PROD_W'(coef[band][term]);
    o_ext    = PROD_W'(opnd);
    prod     = c_ext * o_ext;
    term_val = (term >= 3'd3) ? -ACC_W'(prod) : ACC_W'(prod);

    rnd_sum  = acc + RND;
    scaled   = rnd_sum >>> COEF_FRAC;
    wb_clamp = 1'b0;
    if (scaled > IMAX) begin
      y_sat    = {1'b0, {(INT_W-1){1'b1}}};
      wb_clamp = 1'b1;
    end else if (scaled < IMIN) begin
      y_sat    = {1'b1, {(INT_W-1){1'b0}}};
      wb_clamp = 1'b1;
    end else begin
      y_sat    = scaled[INT_W-1:0];
    end
    // Bypass walks the same band sequence so latency is unchanged, but
    // each band simply forwards its input.
    y_wb = cap_bypass ? x_in : y_sat;

    out_word   = '0;
    done_clamp = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (res[c] > DMAX) begin
        out_word[c*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
        done_clamp = 1'b1;
      end else if (res[c] < DMIN) begin
        out_word[c*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
        done_clamp = 1'b1;
      end else begin
        out_word[c*DATA_W +: DATA_W] = res[c][DATA_W-1:0];
      end
    end
  end

  // Datapath, history, coefficient store and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_sat      <= 1'b0;
      o_drop     <= 1'b0;
      cap_data   <= '0;
      cap_shift  <= '0;
      cap_bypass <= 1'b0;
      x_cur      <= '0;
      ch         <= '0;
      band       <= '0;
      term       <= '0;
      acc        <= '0;
      sat_flag   <= 1'b0;
      pend_valid <= 1'b0;
      pend_band  <= '0;
      pend_idx   <= '0;
      pend_data  <= '0;
      for (int unsigned b = 0; b < NUM_BANDS; b++) begin
        coef[b][0] <= COEF_ONE;
        for (int unsigned k = 1; k < 5; k++) coef[b][k] <= '0;
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        samp[c] <= '0;
        res[c]  <= '0;
        for (int unsigned b = 0; b < NUM_BANDS; b++) begin
          hx1[c][b] <= '0;
          hx2[c][b] <= '0;
          hy1[c][b] <= '0;
          hy2[c][b] <= '0;
        end
      end
    end else begin
      o_valid <= 1'b0;
      o_sat   <= 1'b0;
      o_drop  <= i_valid && (state != S_IDLE);

      // Writes land directly when idle, otherwise park in the pending slot.
      // In the done cycle the slot drains first so a same-cycle write wins.
      if (state == S_IDLE) begin
        if (coef_ok) coef[i_coef_band][i_coef_idx] <= i_coef_data;
      end else if (state == S_DONE) begin
        if (pend_valid) coef[pend_band][pend_idx] <= pend_data;
        pend_valid <= 1'b0;
        if (coef_ok) coef[i_coef_band][i_coef_idx] <= i_coef_data;
      end else if (coef_ok) begin
        pend_valid <= 1'b1;
        pend_band  <= i_coef_band;
        pend_idx   <= i_coef_idx;
        pend_data  <= i_coef_data;
      end

      case (state)
        S_IDLE: begin
          if (i_clr_state) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              for (int unsigned b = 0; b < NUM_BANDS; b++) begin
                hx1[c][b] <= '0;
                hx2[c][b] <= '0;
                hy1[c][b] <= '0;
                hy2[c][b] <= '0;
              end
            end
          end
          if (i_valid) begin
            cap_data   <= i_data;
            cap_shift  <= i_shift;
            cap_bypass <= i_bypass;
          end
        end
        S_LOAD: begin
          for (int unsigned c = 0; c < NUM_CH; c++) samp[c] <= load_val[c];
          ch   <= '0;
          band <= '0;
          term <= '0;
        end
        S_MAC: begin
          acc  <= (term == 3'd0) ? term_val : acc + term_val;
          term <= (term == 3'd4) ? 3'd0 : term + 3'd1;
        end
        S_WB: begin
          if (!cap_bypass) begin
            hx2[ch][band] <= hx1[ch][band];
            hx1[ch][band] <= x_in;
            hy2[ch][band] <= hy1[ch][band];
            hy1[ch][band] <= y_sat;
            if (wb_clamp) sat_flag <= 1'b1;
          end
          x_cur <= y_wb;
          term  <= '0;
          if (band == LAST_BD) begin
            res[ch] <= y_wb;
            band    <= '0;
            if (ch != LAST_CH) ch <= ch + 1'b1;
          end else begin
            band <= band + 1'b1;
          end
        end
        S_DONE: begin
          o_data   <= out_word;
          o_valid  <= 1'b1;
          o_sat    <= sat_flag | done_clamp;
          sat_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_eq_engine.sv
// Directed bench for eq_engine: drives single samples, watches a fixed
// window after each for o_valid/o_drop, and compares against hand-computed
// results.
module tb_eq_engine;

  localparam int DW = 16;
  localparam int CW = 18;

  logic            clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic [2*DW-1:0] i_data;
  logic [2:0]      i_shift;
  logic            i_bypass;
  logic            i_clr_state;
  logic            i_coef_we;
  logic [2:0]      i_coef_band;
  logic [2:0]      i_coef_idx;
  logic [CW-1:0]   i_coef_data;
  logic [2*DW-1:0] o_data;
  logic            o_valid;
  logic            o_busy;
  logic            o_sat;
  logic            o_drop;

  int n_checks = 0;
  int n_errors = 0;

  int r0, r1, rsat, rlat, rnv, rnd, rbusy;

  eq_engine #(
    .DATA_W   (DW),
    .NUM_CH   (2),
    .NUM_BANDS(6),
    .COEF_W   (CW),
    .COEF_FRAC(16),
    .INT_W    (24),
    .MAX_SHIFT(4)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_shift    (i_shift),
    .i_bypass   (i_bypass),
    .i_clr_state(i_clr_state),
    .i_coef_we  (i_coef_we),
    .i_coef_band(i_coef_band),
    .i_coef_idx (i_coef_idx),
    .i_coef_data(i_coef_data),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_busy     (o_busy),
    .o_sat      (o_sat),
    .o_drop     (o_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on a negedge.
  task automatic wcoef(input int band, input int idx, input int val);
    i_coef_we   = 1'b1;
    i_coef_band = 3'(band);
    i_coef_idx  = 3'(idx);
    i_coef_data = CW'(val);
    @(posedge clk);
    @(negedge clk);
    i_coef_we   = 1'b0;
  endtask

  // Issue one sample and observe 90 cycles. drop_at injects a second
  // i_valid plus a band0 b0=0.5 write; rst_at pulses reset mid-flight.
  task automatic send(input int d0, input int d1, input int sh, input bit byp,
                      input bit clr, input int drop_at, input int rst_at);
    i_data      = {DW'(d1), DW'(d0)};
    i_shift     = 3'(sh);
    i_bypass    = byp;
    i_clr_state = clr;
    i_valid     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_valid     = 1'b0;
    i_clr_state = 1'b0;
    i_bypass    = 1'b0;
    rlat = -1; rnv = 0; rnd = 0; rsat = -1; rbusy = -1;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (cyc == 5) rbusy = int'(o_busy);
      if (o_drop) rnd++;
      if (o_valid) begin
        rnv++;
        if (rlat < 0) begin
          rlat = cyc;
          r0   = int'($signed(o_data[DW-1:0]));
          r1   = int'($signed(o_data[2*DW-1:DW]));
          rsat = int'(o_sat);
        end
      end
      if (drop_at > 0 && cyc == drop_at + 1) begin
        i_valid   = 1'b0;
        i_coef_we = 1'b0;
      end
      if (cyc == drop_at) begin
        i_valid     = 1'b1;
        i_coef_we   = 1'b1;
        i_coef_band = 3'd0;
        i_coef_idx  = 3'd0;
        i_coef_data = CW'(32768);
      end
      if (rst_at > 0 && cyc == rst_at + 1) begin
        i_rst = 1'b0;
        check("midrst.o_data", int'(o_data), 0);
        check("midrst.o_busy", int'(o_busy), 0);
      end
      if (cyc == rst_at) i_rst = 1'b1;
    end
  endtask

  task automatic chk_out(input string tag, input int e0, input int e1, input int esat);
    check({tag, ".d0"}, r0, e0);
    check({tag, ".d1"}, r1, e1);
    check({tag, ".sat"}, rsat, esat);
    check({tag, ".lat"}, rlat, 74);
    check({tag, ".nvalid"}, rnv, 1);
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_data = '0; i_shift = '0; i_bypass = 1'b0;
    i_clr_state = 1'b0; i_coef_we = 1'b0; i_coef_band = '0; i_coef_idx = '0;
    i_coef_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    i_rst = 1'b0;
    check("rst.o_data", int'(o_data), 0);
    check("rst.o_valid", int'(o_valid), 0);
    check("rst.o_busy", int'(o_busy), 0);
    check("rst.o_sat", int'(o_sat), 0);
    check("rst.o_drop", int'(o_drop), 0);

    // Identity pass-through
    send(1000, -1000, 0, 0, 0, -1, -1);
    chk_out("ident", 1000, -1000, 0);
    check("ident.busy_mid", rbusy, 1);

    // Band0 gain 0.5, rounding half up, shift handling
    wcoef(0, 0, 32768);
    send(1001, -3, 0, 0, 0, -1, -1);
    chk_out("half", 501, -1, 0);
    send(4000, -4000, 2, 0, 0, -1, -1);
    chk_out("shift2", 500, -500, 0);
    send(4000, -4000, 6, 0, 0, -1, -1);
    chk_out("shift6", 2000, -2000, 0);

    // One-pole feedback impulse response with state clear
    wcoef(0, 0, 65536);
    wcoef(0, 3, -32768);
    send(1000, -1000, 0, 0, 1, -1, -1);
    chk_out("imp0", 1000, -1000, 0);
    send(0, 0, 0, 0, 0, -1, -1);
    chk_out("imp1", 500, -500, 0);
    send(0, 0, 0, 0, 0, -1, -1);
    chk_out("imp2", 250, -250, 0);
    send(0, 0, 0, 0, 1, -1, -1);
    chk_out("clr", 0, 0, 0);

    // Gain ~2 in every band saturates the output
    wcoef(0, 3, 0);
    for (int b = 0; b < 6; b++) wcoef(b, 0, 131071);
    send(30000, -30000, 0, 0, 0, -1, -1);
    chk_out("sat", 32767, -32768, 1);
    send(0, 0, 0, 0, 0, -1, -1);
    chk_out("unsat", 0, 0, 0);

    // Drop while busy; write during busy only affects the next sample
    for (int b = 0; b < 6; b++) wcoef(b, 0, 65536);
    send(100, -100, 0, 0, 0, 10, -1);
    chk_out("drop", 100, -100, 0);
    check("drop.ndrop", rnd, 1);
    send(100, -100, 0, 0, 0, -1, -1);
    chk_out("pend", 50, -50, 0);

    // Bypass leaves history untouched
    wcoef(0, 0, 65536);
    wcoef(0, 3, -32768);
    send(1000, -1000, 0, 0, 1, -1, -1);
    chk_out("pre_byp", 1000, -1000, 0);
    send(1234, -1234, 0, 1, 0, -1, -1);
    chk_out("byp", 1234, -1234, 0);
    send(0, 0, 0, 0, 0, -1, -1);
    chk_out("post_byp", 500, -500, 0);

    // Reset mid-sample aborts output and restores identity coefficients
    wcoef(1, 0, 32768);
    send(1000, -1000, 0, 0, 0, -1, 30);
    check("midrst.nvalid", rnv, 0);
    send(1000, -1000, 0, 0, 0, -1, -1);
    chk_out("ident2", 1000, -1000, 0);
    send(0, 0, 0, 0, 0, -1, -1);
    chk_out("ident3", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
